trng_keccak_ctrl: RTL and testbench
===================================

# trng_keccak_ctrl

Sequencer between the ring-oscillator TRNG core and the Keccak conditioning permutation inside the TRNG/Keccak accelerator attached to the X-HEEP external bus. On request it enables the oscillators and waits for them to settle. It then decimates raw bits into 64-bit lanes, streams one rate block of lanes into the Keccak absorb port, and fires the permutation. An optional repetition-count health test aborts the run on stuck entropy.

## Interface
- `LANE_W`, 64: lane width in bits.
- `LANES_PER_BLOCK`, 17: lanes per absorb block (1088-bit rate).
- `SETTLE_CYCLES`, 16: oscillator warm-up cycles, ≥1.
- `SAMPLE_DIV`, 4: clock cycles per captured raw bit, ≥1.
- `REP_LIMIT`, 32: consecutive identical samples that declare failure, ≥2.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset: **one clock; reset is synchronous and active-high**.
- `start_i`  in  1  request one conditioned block; sampled in IDLE only.
- `ro_en_o`  out  1  ring-oscillator enable.
- `raw_bit_i`  in  1  TRNG bit, already synchronized.
- `lane_valid_o`  out  1  absorb lane valid.
- `lane_ready_i`  in  1  absorb lane ready.
- `lane_data_o`  out  LANE_W  lane payload.
- `lane_last_o`  out  1  final lane of the block.
- `perm_start_o`  out  1  one-cycle permutation trigger.
- `perm_done_i`  in  1  permutation complete pulse.
- `busy_o`  out  1  state ≠ IDLE.
- `done_o`  out  1  one-cycle block-complete pulse.
- `health_fail_o`  out  1  sticky health failure.
- `clear_fail_i`  in  1  leave FAIL.

## Operation
- States: IDLE, SETTLE, COLLECT, PUSH, PERMUTE, DONE, FAIL.
- IDLE + `start_i` → SETTLE. `start_i` is ignored in all other states.
- SETTLE: `ro_en_o`=1. After SETTLE_CYCLES cycles → COLLECT. The divider, bit counter and health counter are cleared on entry.
- COLLECT: the divider counts 0..SAMPLE_DIV-1. On the cycle where it reads SAMPLE_DIV-1, `raw_bit_i` shifts into bit 0 and the register shifts left, so the first captured bit ends in bit 63. After LANE_W captures → PUSH.
- PUSH: `lane_valid_o`=1 and `lane_data_o` is held stable. Sampling is paused and `ro_en_o` stays 1. On `lane_valid_o & lane_ready_i`:
  - if the lane index = LANES_PER_BLOCK-1 → PERMUTE;
  - otherwise index+1 → COLLECT.
- `lane_last_o`=1 while pushing lane LANES_PER_BLOCK-1.
- PERMUTE: `ro_en_o`=0. `perm_start_o`=1 on the first cycle only. `perm_done_i` is honored from the second cycle onward and moves the FSM to DONE.
- DONE: `done_o`=1 for one cycle → IDLE. The lane index resets.
- Health test: tracks the previous sample and a run counter (first sample = 1; +1 if equal, else 1). When the counter reaches REP_LIMIT → FAIL on the next edge, overriding any other transition.
- FAIL: `health_fail_o`=1, all other outputs 0. Any partial lane is discarded. `clear_fail_i` → IDLE with `health_fail_o` cleared; `clear_fail_i` has no effect in any other state.
- `perm_done_i` outside PERMUTE is ignored.

## Timing
- Reset: all outputs 0, state IDLE, all counters and the shift register 0.
- Reset asserted mid-operation: state and outputs are back to reset values at the next edge. No lane or permutation handshake completes.
- From the `start_i` cycle:
  - `ro_en_o` rises 1 cycle later;
  - the first `lane_valid_o` rises 1+SETTLE_CYCLES+LANE_W·SAMPLE_DIV cycles later (273 at defaults).
- Ready may already be high when valid rises; the transfer then completes that cycle. There is no combinational path from `lane_ready_i` to `lane_valid_o`.
- Each later lane: LANE_W·SAMPLE_DIV cycles of COLLECT plus ≥1 PUSH cycle.
- `done_o` rises 1 cycle after the accepted `perm_done_i`.

## Configuration
- `TRNG_CTRL_HEALTH_EN` defined: the repetition test and the FAIL state are present.
- Undefined:
  - the health logic is removed;
  - `health_fail_o` is tied 0;
  - `clear_fail_i` is unused;
  - FAIL is unreachable.

## Structure
- `trng_keccak_ctrl_pkg`: the state enum and the default `LANE_W`/`LANES_PER_BLOCK` constants, shared with the Keccak wrapper and the register interface.
- Sub-module `trng_rep_health_test`: previous-sample register, run counter and fail flag, with a sample strobe and a clear input. It is instantiated only under `TRNG_CTRL_HEALTH_EN`.

## Test plan
- Alternating raw bits 0,1,0,1…, LANES_PER_BLOCK=2, ready always 1:
  - lane 0 = 0x5555_5555_5555_5555 with first valid at cycle 273;
  - `lane_last_o` on lane 1;
  - one `perm_start_o`, and `done_o` one cycle after `perm_done_i`.
- Ready held 0 for 10 cycles in PUSH: `lane_valid_o` and `lane_data_o` remain stable and no sample is captured; the transfer completes on the first ready cycle.
- Constant raw bit 1 with the macro defined: FAIL after 32 samples, `health_fail_o`=1, `ro_en_o`=0, no lane valid. `clear_fail_i` → IDLE and the flag clears.
- Constant raw bit 1 without the macro: a lane of 0xFFFF_FFFF_FFFF_FFFF is pushed and `health_fail_o` stays 0.
- `rst_i` pulsed during COLLECT and during PERMUTE: all outputs 0 next cycle. A following `start_i` produces a fresh timing identical to the first scenario.
- `start_i` held high during the whole run, and `perm_done_i` pulsed while in COLLECT: no restart and no early DONE. A new run starts only after IDLE is re-entered.

Source files
------------

// File: rtl/trng_keccak_ctrl_pkg.sv
// Shared definitions for the TRNG/Keccak sequencer: FSM state encoding and
// the default lane geometry also used by the Keccak wrapper and register block.
package trng_keccak_ctrl_pkg;

    localparam int unsigned TRNG_LANE_W          = 64;
    localparam int unsigned TRNG_LANES_PER_BLOCK = 17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COLLECT,
        ST_PUSH,
        ST_PERMUTE,
        ST_DONE,
        ST_FAIL
    } trng_state_e;

endpackage

// File: rtl/trng_rep_health_test.sv
// Repetition-count health test: counts consecutive identical raw samples and
// raises a sticky fail flag once the run length reaches REP_LIMIT.
module trng_rep_health_test
    import trng_keccak_ctrl_pkg::*;
#(
    parameter int unsigned REP_LIMIT = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic sample_i,
    input  logic bit_i,
    output logic fail_o
);

    localparam int unsigned CW = $clog2(REP_LIMIT + 1);

    logic          prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fail_q, fail_d;

    // Run-length tracking; a zero count marks "no sample seen since clear".
    always_comb begin
        prev_d = prev_q;
        cnt_d  = cnt_q;
        fail_d = fail_q;
        if (clear_i) begin
            prev_d = 1'b0;
            cnt_d  = '0;
            fail_d = 1'b0;
        end else if (sample_i) begin
            prev_d = bit_i;
            if ((cnt_q != '0) && (bit_i == prev_q)) begin
                if (cnt_q != CW'(REP_LIMIT)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                cnt_d = CW'(1);
            end
            if (cnt_d == CW'(REP_LIMIT)) begin
                fail_d = 1'b1;
            end
        end
    end

    // Health state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
            fail_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
            fail_q <= fail_d;
        end
    end

    assign fail_o = fail_q;

endmodule

// File: rtl/trng_keccak_ctrl.sv
// Sequencer between the ring-oscillator TRNG and the Keccak absorb port:
// settle, decimate raw bits into lanes, push one rate block, fire the permutation.
// Optional repetition health test enabled by defining TRNG_CTRL_HEALTH_EN.
module trng_keccak_ctrl
    import trng_keccak_ctrl_pkg::*;
#(
    parameter int unsigned LANE_W          = TRNG_LANE_W,
    parameter int unsigned LANES_PER_BLOCK = TRNG_LANES_PER_BLOCK,
    parameter int unsigned SETTLE_CYCLES   = 16,
    parameter int unsigned SAMPLE_DIV      = 4,
    parameter int unsigned REP_LIMIT       = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              ro_en_o,
    input  logic              raw_bit_i,
    output logic              lane_valid_o,
    input  logic              lane_ready_i,
    output logic [LANE_W-1:0] lane_data_o,
    output logic              lane_last_o,
    output logic              perm_start_o,
    input  logic              perm_done_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              health_fail_o,
    input  logic              clear_fail_i
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned DW = $clog2(SAMPLE_DIV + 1);
    localparam int unsigned BW = $clog2(LANE_W + 1);
    localparam int unsigned LW = $clog2(LANES_PER_BLOCK + 1);

    trng_state_e       state_q, state_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [DW-1:0]     div_q, div_d;
    logic [BW-1:0]     bits_q, bits_d;
    logic [LW-1:0]     lane_q, lane_d;
    logic [LANE_W-1:0] shreg_q, shreg_d;
    logic              perm_armed_q, perm_armed_d;
    logic              sample;
    logic              health_evt;

`ifdef TRNG_CTRL_HEALTH_EN
    logic health_clear;

    // Run tracking restarts whenever the FSM is outside an active collection.
    assign health_clear = (state_q == ST_IDLE) || (state_q == ST_SETTLE) ||
                          (state_q == ST_FAIL);

    trng_rep_health_test #(
        .REP_LIMIT (REP_LIMIT)
    ) u_health (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (health_clear),
        .sample_i (sample),
        .bit_i    (raw_bit_i),
        .fail_o   (health_evt)
    );
`else
    logic unused_health;

    assign health_evt    = 1'b0;
    assign unused_health = clear_fail_i ^ sample ^ (REP_LIMIT < 2);
`endif

    // Next-state, datapath and output decode; a pending health failure overrides all.
    always_comb begin
        state_d       = state_q;
        settle_d      = settle_q;
        div_d         = div_q;
        bits_d        = bits_q;
        lane_d        = lane_q;
        shreg_d       = shreg_q;
        perm_armed_d  = 1'b0;
        sample        = 1'b0;
        ro_en_o       = 1'b0;
        lane_valid_o  = 1'b0;
        lane_data_o   = '0;
        lane_last_o   = 1'b0;
        perm_start_o  = 1'b0;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        health_fail_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                lane_d = '0;
                if (start_i) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end
            end
            ST_SETTLE: begin
                ro_en_o = 1'b1;
                busy_o  = 1'b1;
                if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_COLLECT;
                    div_d   = '0;
                    bits_d  = '0;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            ST_COLLECT: begin
                ro_en_o = 1'b1;
                busy_o  = 1'b1;
                if (div_q == DW'(SAMPLE_DIV - 1)) begin
                    div_d   = '0;
                    sample  = 1'b1;
                    shreg_d = {shreg_q[LANE_W-2:0], raw_bit_i};
                    if (bits_q == BW'(LANE_W - 1)) begin
                        bits_d  = '0;
                        state_d = ST_PUSH;
                    end else begin
                        bits_d = bits_q + BW'(1);
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            ST_PUSH: begin
                ro_en_o      = 1'b1;
                busy_o       = 1'b1;
                lane_valid_o = 1'b1;
                lane_data_o  = shreg_q;
                lane_last_o  = (lane_q == LW'(LANES_PER_BLOCK - 1));
                if (lane_ready_i) begin
                    if (lane_last_o) begin
                        state_d = ST_PERMUTE;
                    end else begin
                        lane_d  = lane_q + LW'(1);
                        state_d = ST_COLLECT;
                    end
                end
            end
            ST_PERMUTE: begin
                busy_o       = 1'b1;
                perm_start_o = !perm_armed_q;
                perm_armed_d = 1'b1;
                if (perm_armed_q && perm_done_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                lane_d  = '0;
                state_d = ST_IDLE;
            end
            ST_FAIL: begin
                health_fail_o = 1'b1;
                shreg_d       = '0;
                if (clear_fail_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The flag is registered, so the lane offer is withdrawn in the cycle
        // it is seen; no handshake can complete alongside the move to FAIL.
        if (health_evt && ((state_q == ST_COLLECT) || (state_q == ST_PUSH))) begin
            state_d      = ST_FAIL;
            lane_valid_o = 1'b0;
            lane_data_o  = '0;
            lane_last_o  = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            settle_q     <= '0;
            div_q        <= '0;
            bits_q       <= '0;
            lane_q       <= '0;
            shreg_q      <= '0;
            perm_armed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            div_q        <= div_d;
            bits_q       <= bits_d;
            lane_q       <= lane_d;
            shreg_q      <= shreg_d;
            perm_armed_q <= perm_armed_d;
        end
    end

endmodule

// File: tb/tb_trng_keccak_ctrl.sv
// Self-checking bench for trng_keccak_ctrl (2-lane blocks). Expected lanes are
// built from the driven raw bits and the decimation rule; timing from the
// cycle budget formula. Health expectations follow TRNG_CTRL_HEALTH_EN.
module tb_trng_keccak_ctrl;

    localparam int unsigned LANE_W = 64;
    localparam int unsigned LPB    = 2;
    localparam int unsigned SETTLE = 16;
    localparam int unsigned DIV    = 4;
    localparam int unsigned REP    = 32;

    logic              clk_i = 1'b0;
    logic              rst_i, start_i, raw_bit_i, lane_ready_i, perm_done_i, clear_fail_i;
    logic              ro_en_o, lane_valid_o, lane_last_o, perm_start_o, busy_o, done_o;
    logic              health_fail_o;
    logic [LANE_W-1:0] lane_data_o;

    int n_checks = 0;
    int n_fail   = 0;
    int perm_starts = 0;
    int dones       = 0;
    int t;

    always #5 clk_i = ~clk_i;

    trng_keccak_ctrl #(
        .LANE_W          (LANE_W),
        .LANES_PER_BLOCK (LPB),
        .SETTLE_CYCLES   (SETTLE),
        .SAMPLE_DIV      (DIV),
        .REP_LIMIT       (REP)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .ro_en_o       (ro_en_o),
        .raw_bit_i     (raw_bit_i),
        .lane_valid_o  (lane_valid_o),
        .lane_ready_i  (lane_ready_i),
        .lane_data_o   (lane_data_o),
        .lane_last_o   (lane_last_o),
        .perm_start_o  (perm_start_o),
        .perm_done_i   (perm_done_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .health_fail_o (health_fail_o),
        .clear_fail_i  (clear_fail_i)
    );

    // Pulse counters sampled mid-cycle.
    always @(negedge clk_i) begin
        if (perm_start_o) perm_starts++;
        if (done_o)       dones++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        t++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {57'd0, ro_en_o, lane_valid_o, lane_last_o, perm_start_o,
                              busy_o, done_o, health_fail_o}, 64'd0);
        check({tag, "_data"}, lane_data_o, 64'd0);
    endtask

    // One full block. mode: 0 alternating samples, 1 random, 2 constant 1.
    task automatic run_block(input int mode, input int ready_low_first, input bit ready_rand,
                             input bit hold_start, input bit spurious_done, input bit rst_in_perm);
        logic [63:0] exp_lane;
        int k, hold, ps0, d0;
        bit b;
        ps0 = perm_starts;
        d0  = dones;
        t = 0;
        start_i = 1'b1;
        lane_ready_i = 1'b1;
        check("idle_busy", busy_o, 1'b0);
        tick();
        if (!hold_start) start_i = 1'b0;
        check("ro_en_rise", ro_en_o, 1'b1);
        check("busy_rise", busy_o, 1'b1);
        repeat (SETTLE) tick();
        for (int lane = 0; lane < int'(LPB); lane++) begin
            exp_lane = '0;
            k = 0;
            for (int c = 0; c < int'(LANE_W * DIV); c++) begin
                case (mode)
                    0:       b = k[0];
                    1:       b = 1'($urandom);
                    default: b = 1'b1;
                endcase
                raw_bit_i    = b;
                perm_done_i  = spurious_done && (c == 40);
                clear_fail_i = (mode == 1) ? 1'($urandom) : 1'b0;
                if (c == 0 || c == int'(LANE_W * DIV) - 1)
                    check("collect_no_valid", lane_valid_o, 1'b0);
                if (c % int'(DIV) == int'(DIV) - 1) begin
                    exp_lane = {exp_lane[62:0], b};
                    k++;
                end
                tick();
            end
            perm_done_i  = 1'b0;
            clear_fail_i = 1'b0;
            if (mode == 0 && lane == 0) check("alt_const", exp_lane, 64'h5555_5555_5555_5555);
            check("lane_valid", lane_valid_o, 1'b1);
            check("lane_data", lane_data_o, exp_lane);
            check("lane_last", lane_last_o, lane == int'(LPB) - 1);
            check("health_ok", health_fail_o, 1'b0);
            hold = (lane == 0) ? ready_low_first : (ready_rand ? int'($urandom_range(0, 3)) : 0);
            if (hold > 0) begin
                lane_ready_i = 1'b0;
                for (int h = 0; h < hold; h++) begin
                    raw_bit_i = ~raw_bit_i;
                    tick();
                    check("hold_valid", lane_valid_o, 1'b1);
                    check("hold_data", lane_data_o, exp_lane);
                end
                lane_ready_i = 1'b1;
            end
            tick();
        end
        // First PERMUTE cycle.
        check("perm_start", perm_start_o, 1'b1);
        check("ro_en_perm", ro_en_o, 1'b0);
        check("valid_perm", lane_valid_o, 1'b0);
        if (rst_in_perm) begin
            rst_i = 1'b1;
            tick();
            rst_i = 1'b0;
            check_all_zero("rst_perm");
            return;
        end
        perm_done_i = spurious_done;
        tick();
        perm_done_i = 1'b0;
        check("perm_start_once", perm_start_o, 1'b0);
        check("no_early_done", done_o, 1'b0);
        repeat ($urandom_range(0, 5)) tick();
        check("busy_perm", busy_o, 1'b1);
        perm_done_i = 1'b1;
        tick();
        perm_done_i = 1'b0;
        check("done_pulse", done_o, 1'b1);
        tick();
        check("done_clear", done_o, 1'b0);
        check("idle_again", busy_o, 1'b0);
        check("perm_start_count", 64'(perm_starts - ps0), 64'd1);
        check("done_count", 64'(dones - d0), 64'd1);
    endtask

    initial begin
        t = 0;
        rst_i = 1'b1;
        start_i = 1'b0;
        raw_bit_i = 1'b0;
        lane_ready_i = 1'b0;
        perm_done_i = 1'b0;
        clear_fail_i = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst_i = 1'b0;
        tick();

        // Alternating samples, ready always high.
        run_block(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Backpressure: ready low for 10 PUSH cycles on lane 0.
        run_block(1, 10, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef TRNG_CTRL_HEALTH_EN
        // Stuck-at-1: the REP-th sample lands at SETTLE+1+(REP-1)*DIV+(DIV-1);
        // the flag registers one cycle later and FAIL is entered on the next edge.
        t = 0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        raw_bit_i = 1'b1;
        while (!health_fail_o && t < 400) begin
            if (lane_valid_o) check("stuck_no_valid", lane_valid_o, 1'b0);
            tick();
        end
        check("fail_cycle", 64'(t), 64'(1 + SETTLE + (REP - 1) * DIV + (DIV - 1) + 2));
        check("fail_flag", health_fail_o, 1'b1);
        check("fail_ro_en", ro_en_o, 1'b0);
        check("fail_valid", lane_valid_o, 1'b0);
        start_i = 1'b1;
        repeat (5) tick();
        check("fail_sticky", health_fail_o, 1'b1);
        start_i = 1'b0;
        clear_fail_i = 1'b1;
        tick();
        clear_fail_i = 1'b0;
        check("fail_cleared", health_fail_o, 1'b0);
        check("fail_to_idle", busy_o, 1'b0);
        tick();
`else
        // Stuck-at-1 without health test: all-ones lanes, no failure.
        run_block(2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        // Reset during COLLECT, then a fresh run with identical timing.
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (100) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_all_zero("rst_collect");
        run_block(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during PERMUTE, then a fresh run.
        run_block(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_block(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // start held throughout plus stray perm_done pulses: restart only from IDLE.
        run_block(1, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check("restart_after_idle", ro_en_o, 1'b1);
        start_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_all_zero("final_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
